// File: rtl/tone_sequencer_if.sv
// Control/status bundle for tone_sequencer: note-table write port, tempo and
// sequencing commands in; divider count, gate and progress status out.
interface tone_sequencer_if #(
    parameter int DEPTH = 16,
    parameter int DUR_W = 16
);
    localparam int AW = $clog2(DEPTH);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [31:0]      wr_count;
    logic [DUR_W-1:0] wr_dur;
    logic             beat_tick;
    logic             start;
    logic             stop;
    logic             loop_en;
    logic [AW-1:0]    last_idx;
    logic [31:0]      div_clk_count;
    logic             tone_en;
    logic             busy;
    logic             done;
    logic [AW-1:0]    cur_idx;

    modport master (
        output wr_en, wr_addr, wr_count, wr_dur, beat_tick, start, stop,
               loop_en, last_idx,
        input  div_clk_count, tone_en, busy, done, cur_idx
    );

    modport slave (
        input  wr_en, wr_addr, wr_count, wr_dur, beat_tick, start, stop,
               loop_en, last_idx,
        output div_clk_count, tone_en, busy, done, cur_idx
    );
endinterface

// File: rtl/tone_sequencer.sv
// Steps through a note table (divide count + duration in beat ticks), gating
// an organ tone divider with a one-tick silent gap between notes.
module tone_sequencer #(
    parameter int DEPTH = 16,
    parameter int DUR_W = 16
) (
    input  logic            inclk,
    input  logic            Reset,
    tone_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PLAY, S_GAP, S_FIN
    } state_t;

    state_t           r_state, w_next_state, w_adv_state;
    logic [AW-1:0]    r_idx, w_next_idx, w_adv_idx;
    logic [DUR_W-1:0] r_ticks, w_next_ticks;
    logic [DUR_W-1:0] r_dur;
    logic [31:0]      r_count;

    logic [31:0]      r_cnt_mem [DEPTH];
    logic [DUR_W-1:0] r_dur_mem [DEPTH];

    // Table is deliberately not reset so a program survives a Reset pulse.
    always_ff @(posedge inclk) begin
        if (bus.wr_en) begin
            r_cnt_mem[bus.wr_addr] <= bus.wr_count;
            r_dur_mem[bus.wr_addr] <= bus.wr_dur;
        end
    end

    always_comb begin
        w_adv_idx   = r_idx;
        w_adv_state = S_FIN;
        if (r_idx != bus.last_idx) begin
            w_adv_idx   = r_idx + 1'b1;
            w_adv_state = S_LOAD;
        end else if (bus.loop_en) begin
            w_adv_idx   = '0;
            w_adv_state = S_LOAD;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_next_ticks = r_ticks;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = S_LOAD;
                    w_next_idx   = '0;
                end
            end
            S_LOAD: begin
                w_next_ticks = '0;
                // Zero-duration entries are skipped without a gap.
                if (r_dur_mem[r_idx] != '0) begin
                    w_next_state = S_PLAY;
                end else begin
                    w_next_state = w_adv_state;
                    w_next_idx   = w_adv_idx;
                end
            end
            S_PLAY: begin
                if (bus.beat_tick) begin
                    if (r_ticks == r_dur - 1'b1) begin
                        w_next_state = S_GAP;
                        w_next_ticks = '0;
                    end else begin
                        w_next_ticks = r_ticks + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (bus.beat_tick) begin
                    w_next_state = w_adv_state;
                    w_next_idx   = w_adv_idx;
                end
            end
            S_FIN:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (bus.stop) begin
            w_next_state = S_IDLE;
            w_next_idx   = r_idx;
            w_next_ticks = r_ticks;
        end
    end

    always_ff @(posedge inclk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_ticks <= '0;
            r_dur   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_ticks <= w_next_ticks;
            if (r_state == S_LOAD) begin
                r_count <= r_cnt_mem[r_idx];
                r_dur   <= r_dur_mem[r_idx];
            end
        end
    end

    assign bus.div_clk_count = r_count;
    assign bus.tone_en       = (r_state == S_PLAY) && (r_count != '0);
    assign bus.busy          = (r_state != S_IDLE);
    assign bus.done          = (r_state == S_FIN);
    assign bus.cur_idx       = r_idx;
endmodule
